// File: rtl/fpu_ctrl_pkg.sv
// rtl/fpu_ctrl_pkg.sv - shared opcodes, flag indices, requester ids and FSM states
package fpu_ctrl_pkg;

   // FPU operation codes
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_SQRT = 3'd4;
   localparam logic [2:0] OP_CMP  = 3'd5;

   // bit positions inside the exception flag vector
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // requester ids: 0 = Wishbone command path, 1 = logic-analyzer path
   localparam logic REQ_ID0 = 1'b0;
   localparam logic REQ_ID1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/fpu_op_arbiter_rr_arbiter2.sv
// rtl/fpu_op_arbiter_rr_arbiter2.sv - two-way round-robin grant, purely combinational
module rr_arbiter2
   import fpu_ctrl_pkg::*;
(
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_last_grant,
   output logic o_gnt_valid,
   output logic o_gnt_id
);

   assign o_gnt_valid = i_valid0 | i_valid1;

   // a lone requester always wins; on a tie the one not served last wins
   assign o_gnt_id = (i_valid0 && i_valid1)
                   ? ((i_last_grant == REQ_ID0) ? REQ_ID1 : REQ_ID0)
                   : (i_valid1 ? REQ_ID1 : REQ_ID0);

endmodule

// File: rtl/fpu_op_arbiter.sv
// rtl/fpu_op_arbiter.sv - schedules one shared FPU datapath between two requesters
module fpu_op_arbiter
   import fpu_ctrl_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int OP_W        = 3,
   parameter int FLAG_W      = 5,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_result,
   output logic [FLAG_W-1:0] rsp0_flags,
   output logic              rsp0_timeout,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_result,
   output logic [FLAG_W-1:0] rsp1_flags,
   output logic              rsp1_timeout,
   output logic              fpu_start,
   output logic [OP_W-1:0]   fpu_op,
   output logic [DATA_W-1:0] fpu_a,
   output logic [DATA_W-1:0] fpu_b,
   input  logic              fpu_done,
   input  logic [DATA_W-1:0] fpu_result,
   input  logic [FLAG_W-1:0] fpu_flags,
   output logic              busy
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_grant;
   logic              r_owner;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_fpu_start;
   logic [OP_W-1:0]   r_fpu_op;
   logic [DATA_W-1:0] r_fpu_a;
   logic [DATA_W-1:0] r_fpu_b;
   logic              r_rsp0_valid;
   logic [DATA_W-1:0] r_rsp0_result;
   logic [FLAG_W-1:0] r_rsp0_flags;
   logic              r_rsp0_timeout;
   logic              r_rsp1_valid;
   logic [DATA_W-1:0] r_rsp1_result;
   logic [FLAG_W-1:0] r_rsp1_flags;
   logic              r_rsp1_timeout;

   logic              w_gnt_valid;
   logic              w_gnt_id;
   logic              w_hs;
   logic              w_cnt_last;
   logic              w_finish;
   logic [OP_W-1:0]   w_sel_op;
   logic [DATA_W-1:0] w_sel_a;
   logic [DATA_W-1:0] w_sel_b;
   logic [DATA_W-1:0] w_res;
   logic [FLAG_W-1:0] w_flags;
   logic              w_to;

   rr_arbiter2 u_rr (
      .i_valid0    (req0_valid),
      .i_valid1    (req1_valid),
      .i_last_grant(r_last_grant),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   // a handshake happens whenever we are idle and somebody is asking
   assign w_hs       = (r_state == ST_IDLE) && w_gnt_valid;
   assign req0_ready = w_hs && (w_gnt_id == REQ_ID0);
   assign req1_ready = w_hs && (w_gnt_id == REQ_ID1);

   assign w_sel_op = (w_gnt_id == REQ_ID1) ? req1_op : req0_op;
   assign w_sel_a  = (w_gnt_id == REQ_ID1) ? req1_a  : req0_a;
   assign w_sel_b  = (w_gnt_id == REQ_ID1) ? req1_b  : req0_b;

   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_finish   = (r_state == ST_WAIT) && (fpu_done || w_cnt_last);

   // done beats the timeout limit when both land on the same cycle
   assign w_res   = fpu_done ? fpu_result : '0;
   assign w_flags = fpu_done ? fpu_flags : '0;
   assign w_to    = ~fpu_done;

   assign busy         = (r_state != ST_IDLE);
   assign fpu_start    = r_fpu_start;
   assign fpu_op       = r_fpu_op;
   assign fpu_a        = r_fpu_a;
   assign fpu_b        = r_fpu_b;
   assign rsp0_valid   = r_rsp0_valid;
   assign rsp0_result  = r_rsp0_result;
   assign rsp0_flags   = r_rsp0_flags;
   assign rsp0_timeout = r_rsp0_timeout;
   assign rsp1_valid   = r_rsp1_valid;
   assign rsp1_result  = r_rsp1_result;
   assign rsp1_flags   = r_rsp1_flags;
   assign rsp1_timeout = r_rsp1_timeout;

   // FSM state register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next-state: IDLE -> ISSUE -> WAIT (until done/timeout) -> RESP -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_gnt_valid) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (w_finish) w_state_nxt = ST_RESP;
         ST_RESP:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // operand latch, issue pulse, timeout counter and per-requester response registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_last_grant   <= REQ_ID1;
         r_owner        <= REQ_ID0;
         r_cnt          <= '0;
         r_fpu_start    <= 1'b0;
         r_fpu_op       <= '0;
         r_fpu_a        <= '0;
         r_fpu_b        <= '0;
         r_rsp0_valid   <= 1'b0;
         r_rsp0_result  <= '0;
         r_rsp0_flags   <= '0;
         r_rsp0_timeout <= 1'b0;
         r_rsp1_valid   <= 1'b0;
         r_rsp1_result  <= '0;
         r_rsp1_flags   <= '0;
         r_rsp1_timeout <= 1'b0;
      end else begin
         r_fpu_start  <= w_hs;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         if (w_hs) begin
            r_fpu_op <= w_sel_op;
            r_fpu_a  <= w_sel_a;
            r_fpu_b  <= w_sel_b;
            r_owner  <= w_gnt_id;
         end
         if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
         end else if ((r_state == ST_WAIT) && !w_finish) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_finish) begin
            if (r_owner == REQ_ID0) begin
               r_rsp0_valid   <= 1'b1;
               r_rsp0_result  <= w_res;
               r_rsp0_flags   <= w_flags;
               r_rsp0_timeout <= w_to;
            end else begin
               r_rsp1_valid   <= 1'b1;
               r_rsp1_result  <= w_res;
               r_rsp1_flags   <= w_flags;
               r_rsp1_timeout <= w_to;
            end
         end
         if (r_state == ST_RESP) r_last_grant <= r_owner;
      end
   end

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// tb/tb_fpu_op_arbiter.sv - scoreboard bench for fpu_op_arbiter
module tb_fpu_op_arbiter;
   localparam int TO = 64;
   localparam int NEVER = 32'h7fffffff;

   typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } stim_t;
   typedef struct { int id; logic [2:0] op; logic [31:0] a; logic [31:0] b; int hs; } hs_t;
   typedef struct { logic [31:0] res; logic [4:0] flags; logic to; int cyc; } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_timeout, rsp1_valid, rsp1_timeout;
   logic [31:0] rsp0_result, rsp1_result;
   logic [4:0]  rsp0_flags, rsp1_flags;
   logic        fpu_start, fpu_done, busy;
   logic [2:0]  fpu_op;
   logic [31:0] fpu_a, fpu_b, fpu_result;
   logic [4:0]  fpu_flags;

   fpu_op_arbiter #(.DATA_W(32), .OP_W(3), .FLAG_W(5), .TIMEOUT_CYC(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .rsp0_timeout(rsp0_timeout),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
      .rsp1_timeout(rsp1_timeout),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
      .busy(busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   stim_t stim_q0[$], stim_q1[$];
   hs_t   issued[$];
   rsp_t  rsp_q0[$], rsp_q1[$];
   int    grant_log[$];
   bit    act0 = 0, act1 = 0;

   int          idle_from = 0;
   int          last_id = 1;
   int          done_cyc = -1;
   int          spur_cyc = -1;
   logic [31:0] done_res = '0;
   logic [4:0]  done_flags = '0;
   int          force_k = 0;
   bit          force_res_en = 0;
   logic [31:0] force_res = '0;
   bit          start_seen = 0;
   int          start_cyc = 0;
   int          last_hs_cyc = 0;
   int          last_rsp_cyc0 = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // FPU side: done pulse on the scheduled cycle (plus optional stray pulse), noise otherwise
   initial begin
      fpu_done = 0; fpu_result = '0; fpu_flags = '0;
      forever begin
         @(posedge clk); #1;
         fpu_done = (cyc == done_cyc) || (cyc == spur_cyc);
         fpu_result = (cyc == done_cyc) ? done_res : $urandom;
         fpu_flags  = (cyc == done_cyc) ? done_flags : 5'($urandom_range(0, 31));
      end
   end

   task automatic drv(input int n);
      stim_t s;
      int cnt;
      forever begin
         @(posedge clk); #1;
         if (n == 0) begin
            if (stim_q0.size() == 0) continue;
            act0 = 1; s = stim_q0.pop_front();
            req0_valid = 1; req0_op = s.op; req0_a = s.a; req0_b = s.b;
         end else begin
            if (stim_q1.size() == 0) continue;
            act1 = 1; s = stim_q1.pop_front();
            req1_valid = 1; req1_op = s.op; req1_a = s.a; req1_b = s.b;
         end
         cnt = 0;
         forever begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) break;
            cnt++;
            if (cnt > 3000) begin chk("ready_wait_timeout", 1, 0); break; end
         end
         @(posedge clk); #1;
         if (n == 0) begin
            req0_valid = 0; req0_a = $urandom; req0_b = $urandom; act0 = 0;
         end else begin
            req1_valid = 0; req1_a = $urandom; req1_b = $urandom; act1 = 0;
         end
      end
   endtask

   initial drv(0);
   initial drv(1);

   // reference model: grant rule, issue timing, FPU latency and expected responses
   initial begin
      bit exp_idle, exp_r0, exp_r1, exp_start;
      int eg, k;
      hs_t h;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (rst) begin
            issued.delete(); rsp_q0.delete(); rsp_q1.delete();
            idle_from = 0; last_id = 1;
            continue;
         end
         exp_idle = (cyc >= idle_from);
         exp_r0 = 0; exp_r1 = 0; eg = 0;
         if (exp_idle && (req0_valid || req1_valid)) begin
            if (req0_valid && req1_valid) eg = 1 - last_id;
            else eg = req1_valid ? 1 : 0;
            exp_r0 = (eg == 0); exp_r1 = (eg == 1);
         end
         chk("req0_ready", req0_ready, exp_r0);
         chk("req1_ready", req1_ready, exp_r1);
         chk("busy", busy, !exp_idle);
         exp_start = (issued.size() > 0) && (issued[0].hs + 1 == cyc);
         chk("fpu_start", fpu_start, exp_start);
         if (exp_start) begin
            h = issued.pop_front();
            chk("fpu_op", fpu_op, h.op);
            chk("fpu_a", fpu_a, h.a);
            chk("fpu_b", fpu_b, h.b);
            k = force_k;
            if (k == 0) begin
               case ($urandom_range(0, 19))
                  0: k = -1;
                  1: k = TO;
                  2: k = TO + 1;
                  default: k = $urandom_range(1, 8);
               endcase
            end
            done_res = force_res_en ? force_res : $urandom;
            done_flags = 5'($urandom_range(0, 31));
            if (k >= 1 && k <= TO) begin
               done_cyc = cyc + k;
               r.res = done_res; r.flags = done_flags; r.to = 0; r.cyc = cyc + k + 1;
            end else begin
               done_cyc = (k > TO) ? cyc + k : -1;
               r.res = '0; r.flags = '0; r.to = 1; r.cyc = cyc + TO + 1;
            end
            idle_from = r.cyc + 1;
            if (h.id == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
            start_seen = 1; start_cyc = cyc;
         end
         if (exp_idle && (req0_valid || req1_valid)) begin
            h.id = eg; h.hs = cyc;
            h.op = (eg == 0) ? req0_op : req1_op;
            h.a  = (eg == 0) ? req0_a : req1_a;
            h.b  = (eg == 0) ? req0_b : req1_b;
            issued.push_back(h);
            last_id = eg; idle_from = NEVER; last_hs_cyc = cyc;
            grant_log.push_back(eg);
         end
      end
   end

   task automatic mon_one(input int n);
      rsp_t r;
      logic v, t;
      logic [31:0] res;
      logic [4:0] fl;
      int qs;
      v = (n == 0) ? rsp0_valid : rsp1_valid;
      res = (n == 0) ? rsp0_result : rsp1_result;
      fl = (n == 0) ? rsp0_flags : rsp1_flags;
      t = (n == 0) ? rsp0_timeout : rsp1_timeout;
      qs = (n == 0) ? rsp_q0.size() : rsp_q1.size();
      if (v) begin
         if (n == 0) last_rsp_cyc0 = cyc;
         if (qs == 0) begin
            chk($sformatf("rsp%0d_unexpected", n), 1, 0);
         end else begin
            r = (n == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
            chk($sformatf("rsp%0d_cycle", n), 64'(cyc), 64'(r.cyc));
            chk($sformatf("rsp%0d_result", n), res, r.res);
            chk($sformatf("rsp%0d_flags", n), fl, r.flags);
            chk($sformatf("rsp%0d_timeout", n), t, r.to);
         end
      end else if (qs > 0) begin
         r = (n == 0) ? rsp_q0[0] : rsp_q1[0];
         if (r.cyc <= cyc) begin
            chk($sformatf("rsp%0d_missing", n), 0, 1);
            if (n == 0) void'(rsp_q0.pop_front()); else void'(rsp_q1.pop_front());
         end
      end
   endtask

   // response monitor
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         mon_one(0);
         mon_one(1);
      end
   end

   task automatic wait_quiet();
      int n = 0;
      while (!(stim_q0.size() == 0 && stim_q1.size() == 0 && !act0 && !act1 &&
               issued.size() == 0 && rsp_q0.size() == 0 && rsp_q1.size() == 0 &&
               cyc >= idle_from)) begin
         @(negedge clk);
         n++;
         if (n > 20000) begin chk("quiet_timeout", 1, 0); break; end
      end
      @(negedge clk);
   endtask

   task automatic push(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      stim_t s;
      s.op = op; s.a = a; s.b = b;
      if (n == 0) stim_q0.push_back(s); else stim_q1.push_back(s);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_start"}, fpu_start, 0);
      chk({tag, "_fpu_opab"}, {fpu_op, fpu_a[15:0], fpu_b[15:0]}, 0);
      chk({tag, "_fpu_a"}, fpu_a, 0);
      chk({tag, "_fpu_b"}, fpu_b, 0);
      chk({tag, "_rsp0"}, {rsp0_valid, rsp0_result, rsp0_flags, rsp0_timeout}, 0);
      chk({tag, "_rsp1"}, {rsp1_valid, rsp1_result, rsp1_flags, rsp1_timeout}, 0);
   endtask

   initial begin
      int s;
      int exp_g[6] = '{0, 1, 0, 1, 0, 1};
      rst = 1;
      req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk_zero_outputs("reset");

      // tie straight after reset, then continuous contention
      grant_log.delete();
      for (int i = 0; i < 3; i++) begin
         push(0, 3'($urandom_range(0, 5)), $urandom, $urandom);
         push(1, 3'($urandom_range(0, 5)), $urandom, $urandom);
      end
      wait_quiet();
      chk("grant_count", 64'(grant_log.size()), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++)
         chk($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));

      // single ADD with a known result
      force_k = 5; force_res_en = 1; force_res = 32'h40400000;
      push(0, 3'd0, 32'h3F800000, 32'h40000000);
      wait_quiet();
      force_res_en = 0;
      chk("single_latency", 64'(last_rsp_cyc0 - last_hs_cyc), 7);
      chk("rsp0_result_held", rsp0_result, 32'h40400000);

      // timeout, then a normal op, then done on the last cycle, then done one cycle late
      force_k = -1; push(1, 3'd3, $urandom, $urandom); wait_quiet();
      chk("timeout_flag_held", rsp1_timeout, 1);
      chk("timeout_result_held", rsp1_result, 0);
      force_k = 3; push(1, 3'd2, $urandom, $urandom); wait_quiet();
      chk("after_timeout_flag", rsp1_timeout, 0);
      force_k = TO; push(0, 3'd1, $urandom, $urandom); wait_quiet();
      chk("last_cycle_done_flag", rsp0_timeout, 0);
      force_k = TO + 1; push(0, 3'd4, $urandom, $urandom); wait_quiet();
      chk("late_done_flag", rsp0_timeout, 1);

      // stray done while idle
      spur_cyc = cyc + 2;
      repeat (5) @(negedge clk);
      chk("spurious_busy", busy, 0);

      // random traffic
      force_k = 0;
      for (int i = 0; i < 30; i++) begin
         push($urandom_range(0, 1), 3'($urandom_range(0, 5)), $urandom, $urandom);
         if ($urandom_range(0, 2) == 0) push($urandom_range(0, 1), 3'($urandom_range(0, 5)), $urandom, $urandom);
         repeat ($urandom_range(0, 10)) @(negedge clk);
      end
      wait_quiet();

      // reset two cycles after the issue pulse
      force_k = 6; start_seen = 0;
      push(0, 3'd2, $urandom, $urandom);
      s = 0;
      while (!start_seen && s < 100) begin @(negedge clk); s++; end
      chk("reset_phase_start_seen", start_seen, 1);
      while (1) begin
         @(posedge clk); #1;
         if (cyc >= start_cyc + 2) break;
      end
      rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk_zero_outputs("midwait_reset");
      repeat (12) @(negedge clk);
      chk("after_late_done_busy", busy, 0);

      // normal op after the abandoned one
      force_k = 2; push(1, 3'd5, $urandom, $urandom);
      wait_quiet();
      chk("post_reset_queues", 64'(rsp_q0.size() + rsp_q1.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
